spi_rspndr: RTL



---
 rtl/spi_rspndr_if.sv | 51 +++++
 rtl/spi_rspndr.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/spi_rspndr_if.sv
// spi_rspndr_if: SPI pins plus host-side rx/tx bundle for spi_rspndr.
// slave: responder side; master: SPI master / host side. MISO_oe only with SPI_RSPNDR_MISO_OE_EN.
interface spi_rspndr_if #(
  parameter int WIDTH = 16
);
  logic             SS_n;
  logic             SCLK;
  logic             MOSI;
  logic             MISO;
`ifdef SPI_RSPNDR_MISO_OE_EN
  logic             MISO_oe;
`endif
  logic [WIDTH-1:0] tx_data;
  logic             wrt_tx;
  logic [WIDTH-1:0] rx_data;
  logic             rdy;
  logic             clr_rdy;
  logic             err;

  modport slave (
    input  SS_n,
    input  SCLK,
    input  MOSI,
    input  tx_data,
    input  wrt_tx,
    input  clr_rdy,
`ifdef SPI_RSPNDR_MISO_OE_EN
    output MISO_oe,
`endif
    output MISO,
    output rx_data,
    output rdy,
    output err
  );

  modport master (
    output SS_n,
    output SCLK,
    output MOSI,
    output tx_data,
    output wrt_tx,
    output clr_rdy,
`ifdef SPI_RSPNDR_MISO_OE_EN
    input  MISO_oe,
`endif
    input  MISO,
    input  rx_data,
    input  rdy,
    input  err
  );
endinterface

// File: rtl/spi_rspndr.sv
// spi_rspndr: oversampled SPI responder; clk/rst plain, SPI pins + rx/tx host bus on bus (slave).
// Receives WIDTH-bit frames MSB first, returns a host-loaded word; optional MISO_oe via SPI_RSPNDR_MISO_OE_EN.
module spi_rspndr #(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  spi_rspndr_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_HI,
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic             ss_s1_q, ss_s2_q, ss_h_q;
  logic             sck_s1_q, sck_s2_q, sck_h_q;
  logic             mosi_s1_q, mosi_s2_q;
  logic [1:0]       prime_q, prime_d;
  logic [WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             miso_q, miso_d;
  logic             rdy_q, rdy_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] ld_val;

  logic ss_fall, ss_rise, sck_rise, sck_fall;

  assign ss_fall  =  ss_h_q & ~ss_s2_q;
  assign ss_rise  = ~ss_h_q &  ss_s2_q;
  assign sck_rise = ~sck_h_q &  sck_s2_q;
  assign sck_fall =  sck_h_q & ~sck_s2_q;
  assign ld_val   = bus.wrt_tx ? bus.tx_data : tx_buf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_s1_q   <= 1'b1;
      ss_s2_q   <= 1'b1;
      ss_h_q    <= 1'b1;
      sck_s1_q  <= 1'b1;
      sck_s2_q  <= 1'b1;
      sck_h_q   <= 1'b1;
      mosi_s1_q <= 1'b1;
      mosi_s2_q <= 1'b1;
    end else begin
      ss_s1_q   <= bus.SS_n;
      ss_s2_q   <= ss_s1_q;
      ss_h_q    <= ss_s2_q;
      sck_s1_q  <= bus.SCLK;
      sck_s2_q  <= sck_s1_q;
      sck_h_q   <= sck_s2_q;
      mosi_s1_q <= bus.MOSI;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT_HI;
      prime_q  <= 2'd0;
      tx_buf_q <= '0;
      tx_sh_q  <= '0;
      rx_sh_q  <= '0;
      rx_q     <= '0;
      cnt_q    <= 5'd0;
      first_q  <= 1'b0;
      miso_q   <= 1'b0;
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prime_q  <= prime_d;
      tx_buf_q <= tx_buf_d;
      tx_sh_q  <= tx_sh_d;
      rx_sh_q  <= rx_sh_d;
      rx_q     <= rx_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      miso_q   <= miso_d;
      rdy_q    <= rdy_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prime_d  = (prime_q == 2'd2) ? prime_q : prime_q + 2'd1;
    tx_buf_d = ld_val;
    tx_sh_d  = tx_sh_q;
    rx_sh_d  = rx_sh_q;
    rx_d     = rx_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    miso_d   = miso_q;
    rdy_d    = bus.clr_rdy ? 1'b0 : rdy_q;
    err_d    = 1'b0;
    unique case (state_q)
      WAIT_HI: begin
        // The sync chain holds its reset value for two clocks;
        // only trust synced SS_n once it reflects the pin.
        if (prime_q == 2'd2 && ss_s2_q)
          state_d = IDLE;
      end
      IDLE: begin
        if (ss_fall) begin
          tx_sh_d = ld_val;
          miso_d  = ld_val[WIDTH-1];
          cnt_d   = 5'd0;
          rdy_d   = 1'b0;
          first_d = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          if (cnt_q == 5'(WIDTH)) begin
            rx_d  = rx_sh_q;
            rdy_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end else if (sck_rise) begin
          rx_sh_d = {rx_sh_q[WIDTH-2:0], mosi_s2_q};
          cnt_d   = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
        end else if (sck_fall) begin
          if (first_q) begin
            first_d = 1'b0;
          end else begin
            tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
            miso_d  = tx_sh_q[WIDTH-2];
          end
        end
      end
      default: state_d = WAIT_HI;
    endcase
  end

`ifdef SPI_RSPNDR_MISO_OE_EN
  assign bus.MISO_oe = (state_q == SHIFT);
  assign bus.MISO    = bus.MISO_oe & miso_q;
`else
  assign bus.MISO    = miso_q;
`endif
  assign bus.rx_data = rx_q;
  assign bus.rdy     = rdy_q;
  assign bus.err     = err_q;

endmodule
